// File: rtl/io_read_sequencer.sv
// io_read_sequencer: stalls an IORead until a debounced confirm press/release, then completes it with the switch value captured on the press
module io_read_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH = 20,
  parameter int SW_WIDTH = 16
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                io_read_req,
  input  logic                confirm_button,
  input  logic [SW_WIDTH-1:0] switches,
  output logic                stall,
  output logic [SW_WIDTH-1:0] io_rdata,
  output logic                io_valid,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  state_t state, next_state;
  logic s1, s2, btn_stable, btn_stable_d, press_evt, release_evt, capture;
  logic [CNT_WIDTH-1:0] counter;
  // Synchronize the button, then accept a new level only after it stays put for DEBOUNCE_CYCLES
  always_ff @(posedge clock) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      btn_stable <= 1'b0;
      btn_stable_d <= 1'b0;
      counter <= '0;
    end else begin
      s1 <= confirm_button;
      s2 <= s1;
      btn_stable_d <= btn_stable;
      if (s2 == btn_stable) counter <= '0;
      else if (counter == LAST) begin
        btn_stable <= s2;
        counter <= '0;
      end else counter <= counter + CNT_WIDTH'(1);
    end
  end
  assign press_evt = btn_stable & ~btn_stable_d;
  assign release_evt = ~btn_stable & btn_stable_d;
  // State register plus switch capture; io_rdata survives an aborted request but not a reset
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      io_rdata <= '0;
    end else begin
      state <= next_state;
      if (capture) io_rdata <= switches;
    end
  end
  // Next state: a press is required in WAIT_PRESS, so a button held on entry is ignored
  always_comb begin
    next_state = state;
    capture = 1'b0;
    case (state)
      IDLE: next_state = io_read_req ? WAIT_PRESS : IDLE;
      WAIT_PRESS: begin
        capture = io_read_req & press_evt;
        next_state = !io_read_req ? IDLE : press_evt ? WAIT_RELEASE : WAIT_PRESS;
      end
      WAIT_RELEASE: next_state = !io_read_req ? IDLE : release_evt ? DONE : WAIT_RELEASE;
      default: next_state = IDLE;
    endcase
  end
  assign stall = io_read_req & ~rst & (state != DONE);
  assign io_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_io_read_sequencer.sv
// tb_io_read_sequencer: directed scoreboard bench for io_read_sequencer with a short debounce window
module tb_io_read_sequencer;
  logic clock, rst, io_read_req, confirm_button, stall, io_valid, busy;
  logic [15:0] switches, io_rdata;
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  io_read_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .SW_WIDTH(16)) dut (
    .clock(clock), .rst(rst), .io_read_req(io_read_req), .confirm_button(confirm_button),
    .switches(switches), .stall(stall), .io_rdata(io_rdata), .io_valid(io_valid), .busy(busy)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // Monitor: every completion must match the next value queued by the stimulus
  always @(negedge clock) begin
    if (io_valid) begin
      chk("valid_expected", {31'd0, io_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("done_rdata", {16'd0, io_rdata}, {16'd0, exp_q.pop_front()});
        chk("done_stall", {31'd0, stall}, 32'd0);
      end
    end
  end
  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (io_valid) seen = 1;
      else chk({tag, "_stall_wait"}, {31'd0, stall}, 32'd1);
    end
    chk({tag, "_valid_seen"}, {31'd0, seen}, 32'd1);
  endtask
  task automatic press_release(input string tag, input logic [15:0] exp);
    confirm_button = 1'b1;
    repeat (10) begin
      tick();
      chk({tag, "_stall_press"}, {31'd0, stall}, 32'd1);
    end
    chk({tag, "_rdata_captured"}, {16'd0, io_rdata}, {16'd0, exp});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    confirm_button = 1'b0;
    wait_valid(tag);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    io_read_req = 1'b0;
    confirm_button = 1'b0;
    switches = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_valid", {31'd0, io_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rdata", {16'd0, io_rdata}, 32'd0);
    switches = 16'h00A5;
    io_read_req = 1'b1;
    #1;
    chk("basic_stall_idle", {31'd0, stall}, 32'd1);
    chk("basic_busy_idle", {31'd0, busy}, 32'd0);
    exp_q.push_back(16'h00A5);
    tick();
    chk("basic_busy_wait", {31'd0, busy}, 32'd1);
    press_release("basic", 16'h00A5);
    io_read_req = 1'b0;
    tick();
    chk("basic_single_pulse", {31'd0, io_valid}, 32'd0);
    chk("basic_idle_busy", {31'd0, busy}, 32'd0);
    chk("basic_idle_stall", {31'd0, stall}, 32'd0);
    switches = 16'h5555;
    io_read_req = 1'b1;
    tick();
    repeat (5) begin
      confirm_button = 1'b1;
      tick();
      confirm_button = 1'b0;
      tick();
    end
    repeat (10) tick();
    chk("bounce_stall", {31'd0, stall}, 32'd1);
    chk("bounce_busy", {31'd0, busy}, 32'd1);
    chk("bounce_rdata", {16'd0, io_rdata}, 32'h00A5);
    io_read_req = 1'b0;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", {16'd0, io_rdata}, 32'h00A5);
    confirm_button = 1'b1;
    repeat (10) tick();
    io_read_req = 1'b1;
    repeat (10) tick();
    chk("held_rdata", {16'd0, io_rdata}, 32'h00A5);
    chk("held_busy", {31'd0, busy}, 32'd1);
    confirm_button = 1'b0;
    repeat (10) tick();
    chk("held_release_rdata", {16'd0, io_rdata}, 32'h00A5);
    chk("held_release_stall", {31'd0, stall}, 32'd1);
    switches = 16'h1234;
    exp_q.push_back(16'h1234);
    press_release("held", 16'h1234);
    io_read_req = 1'b0;
    tick();
    switches = 16'h0001;
    io_read_req = 1'b1;
    exp_q.push_back(16'h0001);
    press_release("b2b_first", 16'h0001);
    tick();
    chk("b2b_restall", {31'd0, stall}, 32'd1);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_no_double", {31'd0, io_valid}, 32'd0);
    switches = 16'h0002;
    exp_q.push_back(16'h0002);
    press_release("b2b_second", 16'h0002);
    io_read_req = 1'b0;
    tick();
    switches = 16'hFFFF;
    io_read_req = 1'b1;
    tick();
    confirm_button = 1'b1;
    repeat (10) tick();
    chk("mid_rdata", {16'd0, io_rdata}, 32'hFFFF);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall_comb", {31'd0, stall}, 32'd0);
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rdata", {16'd0, io_rdata}, 32'h0000);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_valid", {31'd0, io_valid}, 32'd0);
    rst = 1'b0;
    io_read_req = 1'b0;
    confirm_button = 1'b0;
    repeat (12) tick();
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
